i2c_slave_regfile: RTL and testbench

Synthesizable I2C slave with an internal byte-wide register file, attached to the open-drain SCL/SDA bus on the far side of the Wishbone I2C master core. It is the bus partner the master core and the I2C agent's monitor exercise. It decodes START, STOP and repeated START, matches a 7-bit address and ACKs, and supports pointer-based writes and reads with auto-increment. It also mirrors every register write to a local strobe port for the scoreboard.

---
 rtl/i2c_slave_regfile_if.sv | 22 ++
 rtl/i2c_slave_regfile.sv | 215 +++++++++++++++++++++
 tb/tb_i2c_slave_regfile.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_slave_regfile_if.sv
// rtl/i2c_slave_regfile_if.sv - pad and write-strobe bundle for i2c_slave_regfile
interface i2c_slave_regfile_if #(
    parameter int PW = 4
);
    logic          scl_i;
    logic          sda_i;
    logic          sda_oe_o;
    logic          busy_o;
    logic          wr_stb_o;
    logic [PW-1:0] wr_addr_o;
    logic [7:0]    wr_data_o;

    modport slave (
        input  scl_i, sda_i,
        output sda_oe_o, busy_o, wr_stb_o, wr_addr_o, wr_data_o
    );

    modport master (
        output scl_i, sda_i,
        input  sda_oe_o, busy_o, wr_stb_o, wr_addr_o, wr_data_o
    );
endinterface

// File: rtl/i2c_slave_regfile.sv
// rtl/i2c_slave_regfile.sv - I2C slave with pointer-addressed byte register file
module i2c_slave_regfile #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         NUM_REGS   = 16
) (
    input logic                wb_clk_i,
    input logic                wb_rst_i,
    i2c_slave_regfile_if.slave bus
);
    localparam int PW = $clog2(NUM_REGS);
    localparam logic [PW-1:0] PTR_ONE = 1;

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_ADDR      = 4'd1;
    localparam logic [3:0] ST_ADDR_ACK  = 4'd2;
    localparam logic [3:0] ST_PTR       = 4'd3;
    localparam logic [3:0] ST_PTR_ACK   = 4'd4;
    localparam logic [3:0] ST_WDATA     = 4'd5;
    localparam logic [3:0] ST_WDATA_ACK = 4'd6;
    localparam logic [3:0] ST_RDATA     = 4'd7;
    localparam logic [3:0] ST_RDATA_ACK = 4'd8;

    logic [2:0]    scl_sync_q, sda_sync_q;
    logic [3:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic          oe_q, oe_d;
    logic          busy_q, busy_d;
    logic          stb_q, stb_d;
    logic [PW-1:0] waddr_q, waddr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic [7:0]    regs_q [NUM_REGS];
    logic          reg_we;

    logic scl_s, sda_s, scl_rise, scl_fall, sda_rise, sda_fall, start, stop;
    logic [PW-1:0] ptr_inc;
    logic [7:0]    rx_byte, rd_cur, rd_next;

    // Stage [1] is the synchronized level, stage [2] its one-cycle history.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            scl_sync_q <= 3'b111;
            sda_sync_q <= 3'b111;
        end else begin
            scl_sync_q <= {scl_sync_q[1:0], bus.scl_i};
            sda_sync_q <= {sda_sync_q[1:0], bus.sda_i};
        end
    end

    assign scl_s    = scl_sync_q[1];
    assign sda_s    = sda_sync_q[1];
    assign scl_rise = scl_sync_q[1] & ~scl_sync_q[2];
    assign scl_fall = ~scl_sync_q[1] & scl_sync_q[2];
    assign sda_rise = sda_sync_q[1] & ~sda_sync_q[2];
    assign sda_fall = ~sda_sync_q[1] & sda_sync_q[2];
    assign start    = sda_fall & scl_s;
    assign stop     = sda_rise & scl_s;

    assign ptr_inc = ptr_q + PTR_ONE;
    assign rx_byte = {shift_q[6:0], sda_s};
    assign rd_cur  = regs_q[ptr_q];
    assign rd_next = regs_q[ptr_inc];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        ptr_d   = ptr_q;
        oe_d    = oe_q;
        busy_d  = busy_q;
        stb_d   = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        reg_we  = 1'b0;
        if (start) begin
            state_d = ST_ADDR;
            cnt_d   = 4'd0;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
        end else if (stop) begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_d = rx_byte;
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            cnt_d = 4'd8;
                            if (rx_byte[7:1] == SLAVE_ADDR) begin
                                state_d = ST_ADDR_ACK;
                                busy_d  = 1'b1;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end
                    end
                end
                ST_PTR, ST_WDATA: begin
                    if (scl_rise) begin
                        shift_d = rx_byte;
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            cnt_d = 4'd8;
                            if (state_q == ST_PTR) begin
                                ptr_d   = rx_byte[PW-1:0];
                                state_d = ST_PTR_ACK;
                            end else begin
                                reg_we  = 1'b1;
                                stb_d   = 1'b1;
                                waddr_d = ptr_q;
                                wdata_d = rx_byte;
                                ptr_d   = ptr_inc;
                                state_d = ST_WDATA_ACK;
                            end
                        end
                    end
                end
                // First fall opens the ACK slot, the second one (SDA already held) closes it.
                ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
                    if (scl_fall) begin
                        if (!oe_q) begin
                            oe_d = 1'b1;
                        end else begin
                            cnt_d = 4'd0;
                            oe_d  = 1'b0;
                            if (state_q == ST_ADDR_ACK && shift_q[0]) begin
                                shift_d = rd_cur;
                                oe_d    = ~rd_cur[7];
                                state_d = ST_RDATA;
                            end else if (state_q == ST_ADDR_ACK) begin
                                state_d = ST_PTR;
                            end else begin
                                state_d = ST_WDATA;
                            end
                        end
                    end
                end
                ST_RDATA: begin
                    if (scl_rise) begin
                        cnt_d = cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            oe_d    = 1'b0;
                            state_d = ST_RDATA_ACK;
                        end else begin
                            shift_d = {shift_q[6:0], 1'b0};
                            oe_d    = ~shift_q[6];
                        end
                    end
                end
                // A master ACK restarts the counter; the following fall reloads the next byte.
                ST_RDATA_ACK: begin
                    if (scl_rise) begin
                        if (sda_s) begin
                            state_d = ST_IDLE;
                        end else begin
                            cnt_d = 4'd0;
                        end
                    end else if (scl_fall && cnt_q == 4'd0) begin
                        ptr_d   = ptr_inc;
                        shift_d = rd_next;
                        oe_d    = ~rd_next[7];
                        state_d = ST_RDATA;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            shift_q <= 8'h00;
            ptr_q   <= '0;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
            stb_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            ptr_q   <= ptr_d;
            oe_q    <= oe_d;
            busy_q  <= busy_d;
            stb_q   <= stb_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else if (reg_we) begin
            regs_q[ptr_q] <= rx_byte;
        end
    end

    assign bus.sda_oe_o  = oe_q;
    assign bus.busy_o    = busy_q;
    assign bus.wr_stb_o  = stb_q;
    assign bus.wr_addr_o = waddr_q;
    assign bus.wr_data_o = wdata_q;
endmodule

// File: tb/tb_i2c_slave_regfile.sv
// tb/tb_i2c_slave_regfile.sv - directed bench for i2c_slave_regfile acting as the I2C master
module tb_i2c_slave_regfile;
    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;

    int checks   = 0;
    int errors   = 0;
    int stb_cnt  = 0;
    int oe_cnt   = 0;
    int busy_cnt = 0;
    logic [3:0] stb_addr_log [64];
    logic [7:0] stb_data_log [64];

    i2c_slave_regfile_if #(.PW(4)) bus ();

    assign bus.scl_i = scl_m;
    assign bus.sda_i = sda_m & ~bus.sda_oe_o;

    i2c_slave_regfile #(
        .SLAVE_ADDR(7'h50),
        .NUM_REGS  (16)
    ) dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.wr_stb_o) begin
            stb_addr_log[stb_cnt[5:0]] = bus.wr_addr_o;
            stb_data_log[stb_cnt[5:0]] = bus.wr_data_o;
            stb_cnt = stb_cnt + 1;
        end
        if (bus.sda_oe_o) oe_cnt = oe_cnt + 1;
        if (bus.busy_o) busy_cnt = busy_cnt + 1;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clock_bit(input logic b, output logic r);
        wait_clk(4);
        sda_m = b;
        wait_clk(4);
        scl_m = 1'b1;
        wait_clk(4);
        r = bus.sda_i;
        wait_clk(4);
        scl_m = 1'b0;
    endtask

    task automatic i2c_start();
        wait_clk(4);
        sda_m = 1'b1;
        wait_clk(4);
        scl_m = 1'b1;
        wait_clk(8);
        sda_m = 1'b0;
        wait_clk(8);
        scl_m = 1'b0;
    endtask

    task automatic i2c_stop_edge();
        wait_clk(4);
        sda_m = 1'b0;
        wait_clk(4);
        scl_m = 1'b1;
        wait_clk(8);
        sda_m = 1'b1;
    endtask

    task automatic i2c_stop();
        i2c_stop_edge();
        wait_clk(8);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) clock_bit(d[i], r);
        clock_bit(1'b1, r);
        ack = ~r;
    endtask

    task automatic read_byte(input logic master_ack, output logic [7:0] d);
        logic r;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            clock_bit(1'b1, r);
            d = {d[6:0], r};
        end
        clock_bit(~master_ack, r);
    endtask

    initial begin
        logic       ack;
        logic [7:0] rd;
        int         stb0, oe0, busy0;

        wait_clk(5);
        check("reset_sda_oe", 32'(bus.sda_oe_o), 32'd0);
        check("reset_busy", 32'(bus.busy_o), 32'd0);
        check("reset_wr_stb", 32'(bus.wr_stb_o), 32'd0);
        check("reset_wr_addr", 32'(bus.wr_addr_o), 32'd0);
        check("reset_wr_data", 32'(bus.wr_data_o), 32'd0);
        rst = 1'b0;
        wait_clk(10);

        // Write 0x5A, 0xC3 starting at pointer 3.
        stb0 = stb_cnt;
        i2c_start();
        write_byte(8'hA0, ack); check("w_addr_ack", 32'(ack), 32'd1);
        check("w_busy_set", 32'(bus.busy_o), 32'd1);
        write_byte(8'h03, ack); check("w_ptr_ack", 32'(ack), 32'd1);
        write_byte(8'h5A, ack); check("w_d0_ack", 32'(ack), 32'd1);
        write_byte(8'hC3, ack); check("w_d1_ack", 32'(ack), 32'd1);
        i2c_stop_edge();
        wait_clk(2);
        check("w_busy_before_stop_seen", 32'(bus.busy_o), 32'd1);
        wait_clk(1);
        check("w_busy_after_stop", 32'(bus.busy_o), 32'd0);
        wait_clk(8);
        check("w_stb_count", 32'(stb_cnt - stb0), 32'd2);
        check("w_stb0_addr", 32'(stb_addr_log[stb0[5:0]]), 32'd3);
        check("w_stb0_data", 32'(stb_data_log[stb0[5:0]]), 32'h5A);
        check("w_stb1_addr", 32'(stb_addr_log[6'(stb0 + 1)]), 32'd4);
        check("w_stb1_data", 32'(stb_data_log[6'(stb0 + 1)]), 32'hC3);

        // Set pointer 3, repeated START, read two bytes (ACK then NACK).
        stb0 = stb_cnt;
        i2c_start();
        write_byte(8'hA0, ack); check("r_addr_w_ack", 32'(ack), 32'd1);
        write_byte(8'h03, ack); check("r_ptr_ack", 32'(ack), 32'd1);
        i2c_start();
        write_byte(8'hA1, ack); check("r_addr_r_ack", 32'(ack), 32'd1);
        read_byte(1'b1, rd); check("r_byte0", 32'(rd), 32'h5A);
        read_byte(1'b0, rd); check("r_byte1", 32'(rd), 32'hC3);
        wait_clk(6);
        check("r_sda_released", 32'(bus.sda_oe_o), 32'd0);
        i2c_stop();
        check("r_no_strobe", 32'(stb_cnt - stb0), 32'd0);

        // Foreign address 0x42: silent through a 9-byte burst.
        oe0   = oe_cnt;
        busy0 = busy_cnt;
        i2c_start();
        write_byte(8'h84, ack); check("mm_addr_nack", 32'(ack), 32'd0);
        for (int i = 0; i < 9; i++) begin
            write_byte(8'(8'h10 * i + 8'h05), ack);
            if (i == 0 || i == 8) check("mm_data_nack", 32'(ack), 32'd0);
        end
        i2c_stop();
        check("mm_oe_never", 32'(oe_cnt - oe0), 32'd0);
        check("mm_busy_never", 32'(busy_cnt - busy0), 32'd0);

        // Pointer wrap from 15 to 0.
        stb0 = stb_cnt;
        i2c_start();
        write_byte(8'hA0, ack);
        write_byte(8'h0F, ack); check("wrap_ptr_ack", 32'(ack), 32'd1);
        write_byte(8'h11, ack);
        write_byte(8'h22, ack); check("wrap_d1_ack", 32'(ack), 32'd1);
        i2c_stop();
        check("wrap_stb_count", 32'(stb_cnt - stb0), 32'd2);
        check("wrap_stb0_addr", 32'(stb_addr_log[stb0[5:0]]), 32'd15);
        check("wrap_stb0_data", 32'(stb_data_log[stb0[5:0]]), 32'h11);
        check("wrap_stb1_addr", 32'(stb_addr_log[6'(stb0 + 1)]), 32'd0);
        check("wrap_stb1_data", 32'(stb_data_log[6'(stb0 + 1)]), 32'h22);

        // STOP after 4 data bits: no write, pointer 4 survives into the next read.
        stb0 = stb_cnt;
        i2c_start();
        write_byte(8'hA0, ack);
        write_byte(8'h04, ack); check("part_ptr_ack", 32'(ack), 32'd1);
        clock_bit(1'b1, ack);
        clock_bit(1'b0, ack);
        clock_bit(1'b1, ack);
        clock_bit(1'b0, ack);
        i2c_stop();
        check("part_no_strobe", 32'(stb_cnt - stb0), 32'd0);
        check("part_busy_low", 32'(bus.busy_o), 32'd0);
        check("part_oe_low", 32'(bus.sda_oe_o), 32'd0);
        i2c_start();
        write_byte(8'hA1, ack); check("part_read_ack", 32'(ack), 32'd1);
        read_byte(1'b0, rd); check("part_read_data", 32'(rd), 32'hC3);
        i2c_stop();

        // Reset while the slave drives the MSB (0) of 0x5A.
        i2c_start();
        write_byte(8'hA0, ack);
        write_byte(8'h03, ack);
        i2c_start();
        write_byte(8'hA1, ack); check("rst_addr_ack", 32'(ack), 32'd1);
        wait_clk(5);
        check("rst_driving_zero", 32'(bus.sda_oe_o), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_release", 32'(bus.sda_oe_o), 32'd0);
        wait_clk(2);
        sda_m = 1'b1;
        scl_m = 1'b1;
        wait_clk(3);
        rst = 1'b0;
        wait_clk(10);
        check("rst_busy", 32'(bus.busy_o), 32'd0);
        check("rst_wr_addr", 32'(bus.wr_addr_o), 32'd0);
        check("rst_wr_data", 32'(bus.wr_data_o), 32'd0);
        i2c_start();
        write_byte(8'hA1, ack); check("rst_read_ack", 32'(ack), 32'd1);
        read_byte(1'b0, rd); check("rst_read_data", 32'(rd), 32'h00);
        i2c_stop();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
